// File: rtl/regfile_wb_queue.sv
// Writeback queue between the execution units and the register file write port.
// Load and ALU writes enter an in-order FIFO through valid/ready handshakes.
// The head entry drains onto the register file every cycle the queue is non-empty.
// A two-port combinational lookup exposes the youngest pending write per register.
module regfile_wb_queue #(
  parameter int WORD_SIZE   = 32,
  parameter int INDEX_WIDTH = 4,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memValid,
  input  logic [INDEX_WIDTH-1:0]   memRegno,
  input  logic [WORD_SIZE-1:0]     memData,
  output logic                     memReady,
  input  logic                     aluValid,
  input  logic [INDEX_WIDTH-1:0]   aluRegno,
  input  logic [WORD_SIZE-1:0]     aluData,
  output logic                     aluReady,
  output logic                     wrtEn,
  output logic [INDEX_WIDTH-1:0]   wrtRegno,
  output logic [WORD_SIZE-1:0]     wrtData,
  input  logic [INDEX_WIDTH-1:0]   lookRegno1,
  input  logic [INDEX_WIDTH-1:0]   lookRegno2,
  output logic                     lookHit1,
  output logic                     lookHit2,
  output logic [WORD_SIZE-1:0]     lookData1,
  output logic [WORD_SIZE-1:0]     lookData2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INDEX_WIDTH-1:0] ent_regno_q [DEPTH];
  logic [WORD_SIZE-1:0]   ent_data_q  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free_s;
  logic          mem_push_s;
  logic          alu_push_s;
  logic [PW-1:0] alu_idx_s;

  // Handshake: free space comes from registered occupancy only, so a drain
  // in the same cycle never creates room. ALU takes the second slot only
  // when the older load is not also competing for the last one.
  always_comb begin
    free_s = CW'(DEPTH) - count_q;
    if (reset) begin
      memReady = (free_s >= CW'(1));
      aluReady = (free_s >= CW'(2)) || ((free_s >= CW'(1)) && !memValid);
    end else begin
      memReady = 1'b0;
      aluReady = 1'b0;
    end
    mem_push_s = memValid && memReady;
    alu_push_s = aluValid && aluReady;
    // Load is older, so it takes tail and the ALU entry lands behind it.
    alu_idx_s  = tail_q + PW'(mem_push_s);
  end

  // Drain port: head entry is presented whenever the queue holds anything.
  always_comb begin
    wrtEn = reset && (count_q != {CW{1'b0}});
    if (wrtEn) begin
      wrtRegno = ent_regno_q[head_q];
      wrtData  = ent_data_q[head_q];
    end else begin
      wrtRegno = {INDEX_WIDTH{1'b0}};
      wrtData  = {WORD_SIZE{1'b0}};
    end
  end

  // Pointer and occupancy next state: up to two pushes and one pop per cycle.
  always_comb begin
    tail_d  = tail_q + PW'(mem_push_s) + PW'(alu_push_s);
    head_d  = head_q + PW'(wrtEn);
    count_d = count_q + CW'(mem_push_s) + CW'(alu_push_s) - CW'(wrtEn);
  end

  // Pointer and occupancy registers; reset discards every pending entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates every use.
  always_ff @(posedge clk) begin
    if (mem_push_s) begin
      ent_regno_q[tail_q] <= memRegno;
      ent_data_q[tail_q]  <= memData;
    end
    if (alu_push_s) begin
      ent_regno_q[alu_idx_s] <= aluRegno;
      ent_data_q[alu_idx_s]  <= aluData;
    end
  end

  // Bypass lookup: walk occupied entries oldest to youngest so the youngest
  // match overrides; the draining head is still occupied this cycle.
  always_comb begin
    lookHit1  = 1'b0;
    lookHit2  = 1'b0;
    lookData1 = {WORD_SIZE{1'b0}};
    lookData2 = {WORD_SIZE{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      logic          occ;
      logic          m1;
      logic          m2;
      idx       = head_q + PW'($unsigned(i));
      occ       = reset && (CW'($unsigned(i)) < count_q);
      m1        = occ && (ent_regno_q[idx] == lookRegno1);
      m2        = occ && (ent_regno_q[idx] == lookRegno2);
      lookHit1  = lookHit1 | m1;
      lookHit2  = lookHit2 | m2;
      lookData1 = m1 ? ent_data_q[idx] : lookData1;
      lookData2 = m2 ? ent_data_q[idx] : lookData2;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: a table of per-cycle vectors plus
// hand-written pointer-wrap and mid-operation reset sequences.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        memValid, aluValid;
  logic [3:0]  memRegno, aluRegno, lookRegno1, lookRegno2;
  logic [31:0] memData, aluData;
  logic        memReady, aluReady, wrtEn, lookHit1, lookHit2;
  logic [3:0]  wrtRegno;
  logic [31:0] wrtData, lookData1, lookData2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int max_cnt = 0;

  logic [3:0]  log_reg [$];
  logic [31:0] log_dat [$];

  regfile_wb_queue #(.WORD_SIZE(32), .INDEX_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .memValid(memValid), .memRegno(memRegno), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluRegno(aluRegno), .aluData(aluData), .aluReady(aluReady),
    .wrtEn(wrtEn), .wrtRegno(wrtRegno), .wrtData(wrtData),
    .lookRegno1(lookRegno1), .lookRegno2(lookRegno2),
    .lookHit1(lookHit1), .lookHit2(lookHit2),
    .lookData1(lookData1), .lookData2(lookData2),
    .count(count)
  );

  always #5 clk = ~clk;

  // Register file model: record every committed write in order.
  always @(posedge clk) begin
    if (wrtEn === 1'b1) begin
      log_reg.push_back(wrtRegno);
      log_dat.push_back(wrtData);
    end
  end

  // Track peak occupancy.
  always @(negedge clk) begin
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic mv; logic [3:0] mr; logic [31:0] md;
    logic av; logic [3:0] ar; logic [31:0] ad;
    logic [3:0] l1; logic [3:0] l2;
    logic e_mrdy; logic e_ardy; logic e_wen;
    logic [3:0] e_wreg; logic [31:0] e_wd; logic [2:0] e_cnt;
    logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2;
  } vec_t;

  function automatic vec_t mk(
    input logic mv, input logic [3:0] mr, input logic [31:0] md,
    input logic av, input logic [3:0] ar, input logic [31:0] ad,
    input logic [3:0] l1, input logic [3:0] l2,
    input logic e_mrdy, input logic e_ardy, input logic e_wen,
    input logic [3:0] e_wreg, input logic [31:0] e_wd, input logic [2:0] e_cnt,
    input logic e_h1, input logic [31:0] e_d1, input logic e_h2, input logic [31:0] e_d2);
    vec_t v;
    v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad;
    v.l1 = l1; v.l2 = l2; v.e_mrdy = e_mrdy; v.e_ardy = e_ardy; v.e_wen = e_wen;
    v.e_wreg = e_wreg; v.e_wd = e_wd; v.e_cnt = e_cnt;
    v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
    return v;
  endfunction

  task automatic drive_idle();
    memValid = 1'b0; memRegno = 4'd0; memData = 32'd0;
    aluValid = 1'b0; aluRegno = 4'd0; aluData = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wrtEn"}, {31'd0, wrtEn}, 32'd0);
    chk({tag, "_wrtRegno"}, {28'd0, wrtRegno}, 32'd0);
    chk({tag, "_wrtData"}, wrtData, 32'd0);
    chk({tag, "_memReady"}, {31'd0, memReady}, 32'd0);
    chk({tag, "_aluReady"}, {31'd0, aluReady}, 32'd0);
    chk({tag, "_lookHit1"}, {31'd0, lookHit1}, 32'd0);
    chk({tag, "_lookHit2"}, {31'd0, lookHit2}, 32'd0);
    chk({tag, "_lookData1"}, lookData1, 32'd0);
    chk({tag, "_lookData2"}, lookData2, 32'd0);
    chk({tag, "_count"}, {29'd0, count}, 32'd0);
  endtask

  vec_t vecs [14];
  logic [3:0]  exp_r [9];
  logic [31:0] exp_d [9];

  initial begin
    // Expected outputs are sampled just before each rising edge.
    vecs[0]  = mk(0,0,0,            0,0,0,            3,0, 1,1,0, 0,0,0,            0,0,           0,0);
    vecs[1]  = mk(0,0,0,            1,3,32'hDEADBEEF, 3,0, 1,1,0, 0,0,0,            0,0,           0,0);
    vecs[2]  = mk(0,0,0,            0,0,0,            3,0, 1,1,1, 3,32'hDEADBEEF,1, 1,32'hDEADBEEF,0,0);
    vecs[3]  = mk(1,5,32'h11,       1,5,32'h22,       5,0, 1,1,0, 0,0,0,            0,0,           0,0);
    vecs[4]  = mk(0,0,0,            0,0,0,            5,3, 1,1,1, 5,32'h11,2,       1,32'h22,      0,0);
    vecs[5]  = mk(0,0,0,            0,0,0,            5,0, 1,1,1, 5,32'h22,1,       1,32'h22,      0,0);
    vecs[6]  = mk(1,1,32'hA1,       1,2,32'hA2,       0,0, 1,1,0, 0,0,0,            0,0,           0,0);
    vecs[7]  = mk(1,3,32'hA3,       1,4,32'hA4,       4,1, 1,1,1, 1,32'hA1,2,       0,0,           1,32'hA1);
    vecs[8]  = mk(1,6,32'hA6,       1,7,32'hA7,       4,0, 1,0,1, 2,32'hA2,3,       1,32'hA4,      0,0);
    vecs[9]  = mk(0,0,0,            1,7,32'hA7,       7,0, 1,1,1, 3,32'hA3,3,       0,0,           0,0);
    vecs[10] = mk(0,0,0,            0,0,0,            7,6, 1,1,1, 4,32'hA4,3,       1,32'hA7,      1,32'hA6);
    vecs[11] = mk(0,0,0,            0,0,0,            4,0, 1,1,1, 6,32'hA6,2,       0,0,           0,0);
    vecs[12] = mk(0,0,0,            0,0,0,            0,0, 1,1,1, 7,32'hA7,1,       0,0,           0,0);
    vecs[13] = mk(0,0,0,            0,0,0,            0,0, 1,1,0, 0,0,0,            0,0,           0,0);
    exp_r = '{4'd3, 4'd5, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    exp_d = '{32'hDEADBEEF, 32'h11, 32'h22, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA6, 32'hA7};

    // Reset state
    reset = 1'b0;
    drive_idle();
    lookRegno1 = 4'd0; lookRegno2 = 4'd0;
    #1;
    check_all_zero("in_reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_count", {29'd0, count}, 32'd0);
    chk("post_reset_memReady", {31'd0, memReady}, 32'd1);
    chk("post_reset_aluReady", {31'd0, aluReady}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      memValid = vecs[i].mv; memRegno = vecs[i].mr; memData = vecs[i].md;
      aluValid = vecs[i].av; aluRegno = vecs[i].ar; aluData = vecs[i].ad;
      lookRegno1 = vecs[i].l1; lookRegno2 = vecs[i].l2;
      #1;
      chk($sformatf("v%0d_memReady", i), {31'd0, memReady}, {31'd0, vecs[i].e_mrdy});
      chk($sformatf("v%0d_aluReady", i), {31'd0, aluReady}, {31'd0, vecs[i].e_ardy});
      chk($sformatf("v%0d_wrtEn", i), {31'd0, wrtEn}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_wrtRegno", i), {28'd0, wrtRegno}, {28'd0, vecs[i].e_wreg});
      chk($sformatf("v%0d_wrtData", i), wrtData, vecs[i].e_wd);
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_lookHit1", i), {31'd0, lookHit1}, {31'd0, vecs[i].e_h1});
      chk($sformatf("v%0d_lookData1", i), lookData1, vecs[i].e_d1);
      chk($sformatf("v%0d_lookHit2", i), {31'd0, lookHit2}, {31'd0, vecs[i].e_h2});
      chk($sformatf("v%0d_lookData2", i), lookData2, vecs[i].e_d2);
      @(posedge clk); #1;
    end
    drive_idle();
    chk("table_log_size", log_reg.size(), 32'd9);
    for (int i = 0; i < 9 && i < log_reg.size(); i++) begin
      chk($sformatf("table_log%0d_reg", i), {28'd0, log_reg[i]}, {28'd0, exp_r[i]});
      chk($sformatf("table_log%0d_data", i), log_dat[i], exp_d[i]);
    end

    // Pointer wrap: ten back-to-back ALU writes
    log_reg.delete(); log_dat.delete();
    for (int i = 0; i < 10; i++) begin
      aluValid = 1'b1; aluRegno = 4'(i); aluData = 32'(i) * 32'h100;
      #1;
      chk($sformatf("wrap%0d_aluReady", i), {31'd0, aluReady}, 32'd1);
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_count", {29'd0, count}, 32'd0);
    chk("wrap_log_size", log_reg.size(), 32'd10);
    for (int i = 0; i < 10 && i < log_reg.size(); i++) begin
      chk($sformatf("wrap_log%0d_reg", i), {28'd0, log_reg[i]}, 32'(i));
      chk($sformatf("wrap_log%0d_data", i), log_dat[i], 32'(i) * 32'h100);
    end

    // Reset mid-operation with three entries pending
    log_reg.delete(); log_dat.delete();
    memValid = 1'b1; memRegno = 4'd8;  memData = 32'hB8;
    aluValid = 1'b1; aluRegno = 4'd9;  aluData = 32'hB9;
    @(posedge clk); #1;
    memRegno = 4'd10; memData = 32'hBA;
    aluRegno = 4'd11; aluData = 32'hBB;
    @(posedge clk); #1;
    aluValid = 1'b0;
    lookRegno1 = 4'd11; lookRegno2 = 4'd9;
    #1;
    chk("midrst_pre_count", {29'd0, count}, 32'd3);
    chk("midrst_pre_wrtEn", {31'd0, wrtEn}, 32'd1);
    chk("midrst_pre_wrtData", wrtData, 32'hB9);
    chk("midrst_pre_lookData1", lookData1, 32'hBB);
    chk("midrst_pre_lookHit2", {31'd0, lookHit2}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrst_low");
    memValid = 1'b0;
    #4;
    reset = 1'b1;
    #2;
    chk("midrst_post_count", {29'd0, count}, 32'd0);
    chk("midrst_post_wrtEn", {31'd0, wrtEn}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_log_size", log_reg.size(), 32'd1);
    if (log_reg.size() > 0) begin
      chk("midrst_log0_data", log_dat[0], 32'hB8);
    end
    chk("max_count", 32'(max_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
